if_stage: RTL and testbench

Instruction fetch stage of the pipelined MIPS core: holds the PC, the program instruction memory and the IF/ID pipeline register. Feeds the ID stage, whose control unit decodes `o_op`/`o_func` and whose hazard unit drives stall and flush back here. Program memory is loaded over a word-write port while the core is disabled. Sequential fetch, redirect, halt detection and bubble insertion all live in this block.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage of the pipelined MIPS core. Holds the program
// counter, the instruction memory and the IF/ID pipeline register.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_reset          asynchronous active-low reset of PC, IF/ID and halt flag
//   i_enable         run enable; low freezes PC, IF/ID and halt flag
//   i_stall          hold PC and IF/ID (load-use hazard from ID)
//   i_flush          redirect taken in ID: load new PC, insert a bubble
//   i_pc_src         redirect target select: 00 PC+4, 01 branch, 10 jump, 11 reg
//   i_branch_addr    branch target byte address
//   i_jump_addr      J/JAL target byte address
//   i_jr_addr        JR/JALR target byte address
//   i_wr_en          program-memory write strobe (only while i_enable is low)
//   i_wr_addr        word address for program write
//   i_wr_data        instruction word to write
//   o_instruction    IF/ID instruction
//   o_pc_plus4       IF/ID PC+4 of that instruction
//   o_op / o_func    opcode and function fields of o_instruction
//   o_valid          IF/ID holds a real instruction (0 = bubble)
//   o_halt           sticky: HALT_WORD latched into IF/ID
//   o_pc             current PC (debug view of the fetch state)
// -----------------------------------------------------------------------------
module if_stage #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [1:0]        i_pc_src,
    input  logic [DATA_W-1:0] i_branch_addr,
    input  logic [DATA_W-1:0] i_jump_addr,
    input  logic [DATA_W-1:0] i_jr_addr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_instruction,
    output logic [DATA_W-1:0] o_pc_plus4,
    output logic [5:0]        o_op,
    output logic [5:0]        o_func,
    output logic              o_valid,
    output logic              o_halt,
    output logic [DATA_W-1:0] o_pc
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] PC_STEP   = DATA_W'(4);
    // Targets are byte addresses; the low two bits are dropped so the PC
    // always stays word aligned.
    localparam logic [DATA_W-1:0] WORD_MASK = ~DATA_W'(3);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic              halt_q, halt_d;

    logic [DATA_W-1:0] fetch_word;
    logic [DATA_W-1:0] seq_pc;
    logic [DATA_W-1:0] redirect_pc;

    // PC bits above the memory index simply wrap modulo the memory depth.
    assign fetch_word = mem_q[pc_q[ADDR_W+1:2]];
    assign seq_pc     = pc_q + PC_STEP;

    always_comb begin
        redirect_pc = seq_pc;
        case (i_pc_src)
            2'b01:   redirect_pc = i_branch_addr & WORD_MASK;
            2'b10:   redirect_pc = i_jump_addr & WORD_MASK;
            2'b11:   redirect_pc = i_jr_addr & WORD_MASK;
            default: redirect_pc = seq_pc;
        endcase
    end

    // Program memory has no reset: a reset pulse must not erase the program.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_enable) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (!i_enable) begin
            // frozen for debug step / program load
        end else if (i_flush) begin
            // Anything fetched after the redirecting instruction, including
            // a HALT, was on the wrong path, so the halt flag is dropped too.
            pc_d    = redirect_pc;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
            halt_d  = 1'b0;
        end else if (i_stall || halt_q) begin
            // hold everything
        end else if (fetch_word == HALT_WORD) begin
            // Present the HALT to ID once, then park the PC on it.
            instr_d = fetch_word;
            pc4_d   = seq_pc;
            valid_d = 1'b1;
            halt_d  = 1'b1;
        end else begin
            instr_d = fetch_word;
            pc4_d   = seq_pc;
            valid_d = 1'b1;
            pc_d    = seq_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_pc_plus4    = pc4_q;
    assign o_op          = instr_q[31:26];
    assign o_func        = instr_q[5:0];
    assign o_valid       = valid_q;
    assign o_halt        = halt_q;
    assign o_pc          = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: directed scenarios from the fetch rules
// plus a randomized run, all checked against a per-edge reference model.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam int          DEPTH = 256;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    // ---------------- clock / reset / DUT ----------------
    logic        i_clk = 1'b0;
    logic        i_reset, i_enable, i_stall, i_flush, i_wr_en;
    logic [1:0]  i_pc_src;
    logic [31:0] i_branch_addr, i_jump_addr, i_jr_addr, i_wr_data;
    logic [7:0]  i_wr_addr;
    logic [31:0] o_instruction, o_pc_plus4, o_pc;
    logic [5:0]  o_op, o_func;
    logic        o_valid, o_halt;

    always #5 i_clk = ~i_clk;

    if_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_stall(i_stall), .i_flush(i_flush), .i_pc_src(i_pc_src),
        .i_branch_addr(i_branch_addr), .i_jump_addr(i_jump_addr),
        .i_jr_addr(i_jr_addr), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .o_instruction(o_instruction),
        .o_pc_plus4(o_pc_plus4), .o_op(o_op), .o_func(o_func),
        .o_valid(o_valid), .o_halt(o_halt), .o_pc(o_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Architectural view: a word array, a byte PC, and the IF/ID contents.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halt;

    task automatic m_rst();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
    endtask

    // Apply one rising edge to the model using the inputs now on the pins.
    task automatic model_edge();
        logic [31:0] w;
        w = m_mem[(m_pc / 4) % DEPTH];
        if (i_enable) begin
            if (i_flush) begin
                case (i_pc_src)
                    2'd0: m_pc = m_pc + 4;
                    2'd1: m_pc = (i_branch_addr / 4) * 4;
                    2'd2: m_pc = (i_jump_addr / 4) * 4;
                    default: m_pc = (i_jr_addr / 4) * 4;
                endcase
                m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
            end else if (!i_stall && !m_halt) begin
                m_instr = w; m_pc4 = m_pc + 4; m_valid = 1;
                if (w == HALT) m_halt = 1;
                else m_pc = m_pc + 4;
            end
        end
        if (i_wr_en && !i_enable) m_mem[i_wr_addr] = i_wr_data;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_stall = 0; i_flush = 0; i_pc_src = 0; i_wr_en = 0;
        i_branch_addr = 0; i_jump_addr = 0; i_jr_addr = 0;
        i_wr_addr = 0; i_wr_data = 0;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] d);
        i_enable = 0; i_wr_en = 1; i_wr_addr = a; i_wr_data = d;
        step();
        i_wr_en = 0;
    endtask

    // Pulse reset away from the clock edge, then leave the core disabled.
    task automatic pulse_reset();
        i_enable = 0;
        #1 i_reset = 0;
        m_rst();
        #1 i_reset = 1;
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        i_enable = 0;
        i_reset = 1;
        #2 i_reset = 0;
        m_rst();
        #1;
        n_cmp++;
        if ({o_instruction, o_pc_plus4, o_pc, o_valid, o_halt} !== 98'd0)
            begin n_bad++; $display("FAIL reset_state got=%h exp=0",
                {o_instruction, o_pc_plus4, o_pc, o_valid, o_halt}); end
        #3 i_reset = 1;
        @(posedge i_clk); #1;
    endtask

    task automatic load_program();
        logic [31:0] w;
        for (int a = 0; a < DEPTH; a++) begin
            w = $urandom();
            if (w == HALT) w = 32'h0;
            write_word(8'(a), w);
        end
        write_word(8'd0, 32'h2001_0005);
        write_word(8'd1, 32'h2002_0003);
        write_word(8'd2, HALT);
    endtask

    task automatic test_program();
        pulse_reset();
        i_enable = 1;
        step();
        n_cmp++;
        if (o_instruction !== 32'h2001_0005 || o_op !== 6'b001000 || o_pc_plus4 !== 32'd4
            || o_valid !== 1'b1 || o_func !== 6'h05)
            begin n_bad++; $display("FAIL fetch0 got=%h op=%b p4=%h v=%b exp=20010005 op=001000 p4=4 v=1",
                o_instruction, o_op, o_pc_plus4, o_valid); end
        step();
        n_cmp++;
        if (o_instruction !== 32'h2002_0003 || o_pc_plus4 !== 32'd8 || o_pc !== 32'd8)
            begin n_bad++; $display("FAIL fetch1 got=%h p4=%h pc=%h exp=20020003 p4=8 pc=8",
                o_instruction, o_pc_plus4, o_pc); end
        step();
        n_cmp++;
        if (o_instruction !== HALT || o_halt !== 1'b1 || o_pc_plus4 !== 32'd12 || o_valid !== 1'b1)
            begin n_bad++; $display("FAIL halt_fetch got=%h halt=%b p4=%h exp=ffffffff halt=1 p4=c",
                o_instruction, o_halt, o_pc_plus4); end
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++;
            if (o_pc !== 32'd8 || o_halt !== 1'b1 || o_instruction !== HALT)
                begin n_bad++; $display("FAIL halt_hold k=%0d pc=%h halt=%b exp pc=8 halt=1",
                    k, o_pc, o_halt); end
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        i_enable = 1;
        step();
        step();
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (o_instruction !== 32'h2002_0003 || o_pc !== 32'd8 || o_pc_plus4 !== 32'd8)
                begin n_bad++; $display("FAIL stall_hold k=%0d instr=%h pc=%h exp 20020003 pc=8",
                    k, o_instruction, o_pc); end
        end
        i_stall = 0;
        step();
        n_cmp++;
        if (o_instruction !== HALT || o_halt !== 1'b1)
            begin n_bad++; $display("FAIL stall_release instr=%h halt=%b exp ffffffff halt=1",
                o_instruction, o_halt); end
    endtask

    task automatic test_flush();
        logic [31:0] tgt [4];
        logic [31:0] raw [4];
        write_word(8'd2, 32'h0123_4567);
        pulse_reset();
        i_enable = 1;
        step(); step(); step();
        n_cmp++;
        if (o_pc !== 32'h0C)
            begin n_bad++; $display("FAIL pre_flush_pc got=%h exp=c", o_pc); end
        raw[1] = 32'h20; raw[2] = 32'h40; raw[3] = 32'h13;
        tgt[1] = 32'h20; tgt[2] = 32'h40; tgt[3] = 32'h10;
        for (int s = 1; s <= 3; s++) begin
            i_flush = 1; i_pc_src = 2'(s);
            i_branch_addr = raw[1]; i_jump_addr = raw[2]; i_jr_addr = raw[3];
            step();
            i_flush = 0;
            n_cmp++;
            if (o_valid !== 1'b0 || o_instruction !== 32'd0 || o_pc !== tgt[s])
                begin n_bad++; $display("FAIL flush_bubble src=%0d v=%b instr=%h pc=%h exp v=0 instr=0 pc=%h",
                    s, o_valid, o_instruction, o_pc, tgt[s]); end
            step();
            n_cmp++;
            if (o_instruction !== m_mem[tgt[s] / 4] || o_pc_plus4 !== tgt[s] + 4 || o_valid !== 1'b1)
                begin n_bad++; $display("FAIL flush_target src=%0d instr=%h p4=%h exp instr=%h p4=%h",
                    s, o_instruction, o_pc_plus4, m_mem[tgt[s] / 4], tgt[s] + 4); end
        end
        // pc_src 00: plain bubble, PC advances by one word
        i_flush = 1; i_pc_src = 2'd0;
        step();
        i_flush = 0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_pc !== 32'h18)
            begin n_bad++; $display("FAIL flush_seq v=%b pc=%h exp v=0 pc=18", o_valid, o_pc); end
        // PC+4 wraps at the top of the address space
        i_flush = 1; i_pc_src = 2'd3; i_jr_addr = 32'hFFFF_FFFE;
        step();
        i_flush = 0;
        step();
        n_cmp++;
        if (o_pc_plus4 !== 32'd0 || o_pc !== 32'd0 || o_instruction !== m_mem[255])
            begin n_bad++; $display("FAIL pc_wrap p4=%h pc=%h instr=%h exp p4=0 pc=0 instr=%h",
                o_pc_plus4, o_pc, o_instruction, m_mem[255]); end
    endtask

    task automatic test_flush_stall_halt();
        i_flush = 1; i_stall = 1; i_pc_src = 2'd1; i_branch_addr = 32'h28;
        step();
        i_flush = 0; i_stall = 0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_pc !== 32'h28)
            begin n_bad++; $display("FAIL flush_over_stall v=%b pc=%h exp v=0 pc=28", o_valid, o_pc); end
        write_word(8'd2, HALT);
        pulse_reset();
        i_enable = 1;
        step(); step(); step();
        i_flush = 1; i_pc_src = 2'd2; i_jump_addr = 32'h30;
        step();
        i_flush = 0;
        n_cmp++;
        if (o_halt !== 1'b0 || o_valid !== 1'b0 || o_pc !== 32'h30)
            begin n_bad++; $display("FAIL halt_flush halt=%b v=%b pc=%h exp halt=0 v=0 pc=30",
                o_halt, o_valid, o_pc); end
        step();
        n_cmp++;
        if (o_instruction !== m_mem[12] || o_valid !== 1'b1 || o_pc !== 32'h34)
            begin n_bad++; $display("FAIL halt_resume instr=%h pc=%h exp instr=%h pc=34",
                o_instruction, o_pc, m_mem[12]); end
    endtask

    task automatic test_async_reset();
        #2 i_reset = 0;
        m_rst();
        #1;
        n_cmp++;
        if ({o_instruction, o_pc_plus4, o_pc, o_valid, o_halt} !== 98'd0)
            begin n_bad++; $display("FAIL async_reset got=%h exp=0",
                {o_instruction, o_pc_plus4, o_pc, o_valid, o_halt}); end
        @(posedge i_clk); #1;
        i_reset = 1;
        step();
        n_cmp++;
        if (o_instruction !== 32'h2001_0005 || o_pc !== 32'd4)
            begin n_bad++; $display("FAIL mem_intact instr=%h pc=%h exp 20010005 pc=4",
                o_instruction, o_pc); end
    endtask

    task automatic test_wr_ignored_and_freeze();
        logic [31:0] s_instr, s_pc, s_pc4;
        i_wr_en = 1; i_wr_addr = 8'd0; i_wr_data = 32'hDEAD_BEEF;
        step(); step();
        i_wr_en = 0;
        pulse_reset();
        i_enable = 1;
        step();
        n_cmp++;
        if (o_instruction !== 32'h2001_0005)
            begin n_bad++; $display("FAIL wr_while_enabled instr=%h exp 20010005", o_instruction); end
        s_instr = m_instr; s_pc = m_pc; s_pc4 = m_pc4;
        i_enable = 0; i_stall = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (o_instruction !== s_instr || o_pc !== s_pc || o_pc_plus4 !== s_pc4
                || o_valid !== 1'b1 || o_halt !== 1'b0)
                begin n_bad++; $display("FAIL enable_freeze k=%0d instr=%h pc=%h exp instr=%h pc=%h",
                    k, o_instruction, o_pc, s_instr, s_pc); end
        end
        i_enable = 1;
        step();
        n_cmp++;
        if (o_instruction !== 32'h2002_0003 || o_pc !== 32'd8)
            begin n_bad++; $display("FAIL enable_resume instr=%h pc=%h exp 20020003 pc=8",
                o_instruction, o_pc); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            i_enable = ($urandom_range(0, 9) != 0);
            i_stall  = ($urandom_range(0, 4) == 0);
            i_flush  = ($urandom_range(0, 7) == 0);
            i_pc_src = 2'($urandom_range(0, 3));
            i_branch_addr = 32'($urandom_range(0, 1023));
            i_jump_addr   = 32'($urandom_range(0, 4095));
            i_jr_addr     = $urandom();
            i_wr_en   = $urandom_range(0, 1) == 1;
            i_wr_addr = 8'($urandom_range(0, 255));
            i_wr_data = ($urandom_range(0, 4) == 0) ? HALT : $urandom();
            step();
            n_cmp++;
            if ({o_instruction, o_pc_plus4, o_pc, o_valid, o_halt, o_op, o_func} !==
                {m_instr, m_pc4, m_pc, m_valid, m_halt, m_instr[31:26], m_instr[5:0]})
                begin n_bad++; $display("FAIL random c=%0d got i=%h p4=%h pc=%h v=%b h=%b exp i=%h p4=%h pc=%h v=%b h=%b",
                    c, o_instruction, o_pc_plus4, o_pc, o_valid, o_halt,
                    m_instr, m_pc4, m_pc, m_valid, m_halt); end
        end
        idle_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        load_program();
        test_program();
        test_stall();
        test_flush();
        test_flush_stall_halt();
        write_word(8'd2, 32'h0123_4567);
        pulse_reset();
        i_enable = 1;
        step(); step();
        test_async_reset();
        test_wr_ignored_and_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
